// File: rtl/wishbone_nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wishbone_nn_pkg                                                      |
// | Shared FSM encodings and CTRL/STATUS register bit positions.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wishbone_nn_pkg;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WAIT = 2'd1,
        B_ACK  = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        N_IDLE  = 2'd0,
        N_ARMED = 2'd1,
        N_RUN   = 2'd2
    } seq_state_t;

    localparam int c_CTRL_START     = 0;
    localparam int c_CTRL_CLEAR     = 1;
    localparam int c_CTRL_IRQ_EN    = 2;
    localparam int c_CTRL_LEN_LSB   = 8;

    localparam int c_STAT_BUSY      = 0;
    localparam int c_STAT_DONE      = 1;
    localparam int c_STAT_OVF       = 2;
    localparam int c_STAT_IRQ_EN    = 3;
    localparam int c_STAT_COUNT_LSB = 8;
    localparam int c_STAT_LEN_LSB   = 16;

endpackage
`default_nettype wire

// File: rtl/wishbone_nn_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_run_sequencer                                                     |
// | Arms the NN core, starts it once enough words are queued, and        |
// | captures the result on completion.                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nn_run_sequencer
    import wishbone_nn_pkg::*;
#(
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic               i_len_we,
    input  logic [DEPTH_W:0]   i_len,
    input  logic [DEPTH_W:0]   i_fifo_count,
    input  logic               i_nn_done,
    input  logic [31:0]        i_nn_result,
    output logic               o_busy,
    output logic               o_done,
    output logic [DEPTH_W:0]   o_len,
    output logic [31:0]        o_result,
    output logic               o_nn_start,
    output logic [DEPTH_W:0]   o_nn_len
);

    seq_state_t         r_state;
    logic [DEPTH_W:0]   r_len;
    logic [DEPTH_W:0]   r_run_len;
    logic [31:0]        r_result;
    logic               r_done;
    logic               r_nn_start;
    logic [DEPTH_W:0]   w_len_next;

    // A start written together with a new length arms on that new length.
    assign w_len_next = i_len_we ? i_len : r_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= N_IDLE;
            r_len      <= '0;
            r_run_len  <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_nn_start <= 1'b0;
        end else begin
            r_nn_start <= 1'b0;
            if (i_len_we) r_len <= i_len;
            if (i_clear) r_done <= 1'b0;
            case (r_state)
                N_IDLE: begin
                    if (i_start && (w_len_next != '0)) begin
                        r_run_len <= w_len_next;
                        r_state   <= N_ARMED;
                    end
                end
                N_ARMED: begin
                    if (i_fifo_count >= r_run_len) begin
                        r_nn_start <= 1'b1;
                        r_state    <= N_RUN;
                    end
                end
                N_RUN: begin
                    // Completion wins over a same-cycle clear.
                    if (i_nn_done) begin
                        r_result <= i_nn_result;
                        r_done   <= 1'b1;
                        r_state  <= N_IDLE;
                    end
                end
                default: r_state <= N_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == N_ARMED) || (r_state == N_RUN);
    assign o_done     = r_done;
    assign o_len      = r_len;
    assign o_result   = r_result;
    assign o_nn_start = r_nn_start;
    assign o_nn_len   = r_run_len;

endmodule
`default_nettype wire

// File: rtl/wishbone_nn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wishbone_nn_ctrl                                                     |
// | Wishbone slave: FIFO push port with back-pressure timeout, CTRL/     |
// | STATUS register and NN run sequencing.                               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wishbone_nn_ctrl
    import wishbone_nn_pkg::*;
#(
    parameter logic [31:0] IO_ADDRESS   = 32'h3000_0000,
    parameter logic [31:0] CTRL_ADDRESS = IO_ADDRESS + 32'd4,
    parameter int          DEPTH_W      = 4,
    parameter int          TIMEOUT      = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               fifo_push_o,
    output logic [31:0]        fifo_wdata_o,
    input  logic               fifo_full_i,
    input  logic [DEPTH_W:0]   fifo_count_i,
    output logic               nn_start_o,
    output logic [DEPTH_W:0]   nn_len_o,
    input  logic               nn_done_i,
    input  logic [31:0]        nn_result_i,
    output logic               irq_o
);

    localparam int             c_TIMER_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(TIMEOUT - 1);

    bus_state_t              r_bstate;
    logic [c_TIMER_W-1:0]    r_timer;
    logic                    r_ack;
    logic [31:0]             r_dat;
    logic                    r_ovf;
    logic                    r_irq_en;

    logic                    w_req, w_io, w_ctrl, w_hit, w_full_sel;
    logic                    w_push, w_ctrl_wr;
    logic                    w_start, w_clear, w_len_we;
    logic                    w_busy, w_done;
    logic [DEPTH_W:0]        w_len;
    logic [31:0]             w_result;
    logic [31:0]             w_status;

    assign w_req      = wbs_stb_i & wbs_cyc_i;
    assign w_io       = (wbs_adr_i == IO_ADDRESS);
    assign w_ctrl     = (wbs_adr_i == CTRL_ADDRESS);
    assign w_hit      = w_req & (w_io | w_ctrl);
    assign w_full_sel = (wbs_sel_i == 4'hF);

    // Push is combinational so the word lands in the FIFO in the cycle it is accepted.
    assign w_push = wb_rst_ni & w_full_sel & ~fifo_full_i &
                    (((r_bstate == B_IDLE) & w_hit & wbs_we_i & w_io) |
                     ((r_bstate == B_WAIT) & w_req));

    assign w_ctrl_wr = (r_bstate == B_IDLE) & w_hit & wbs_we_i & w_ctrl;
    assign w_start   = w_ctrl_wr & wbs_sel_i[0] & wbs_dat_i[c_CTRL_START];
    assign w_clear   = w_ctrl_wr & wbs_sel_i[0] & wbs_dat_i[c_CTRL_CLEAR];
    assign w_len_we  = w_ctrl_wr & wbs_sel_i[1];

    always_comb begin
        w_status = '0;
        w_status[c_STAT_BUSY]   = w_busy;
        w_status[c_STAT_DONE]   = w_done;
        w_status[c_STAT_OVF]    = r_ovf;
        w_status[c_STAT_IRQ_EN] = r_irq_en;
        w_status[c_STAT_COUNT_LSB +: 8]         = 8'(fifo_count_i);
        w_status[c_STAT_LEN_LSB +: DEPTH_W + 1] = w_len;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_bstate <= B_IDLE;
            r_timer  <= '0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_clear) r_ovf <= 1'b0;
            if (w_ctrl_wr && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[c_CTRL_IRQ_EN];
            case (r_bstate)
                B_IDLE: begin
                    if (w_hit) begin
                        if (wbs_we_i && w_io && fifo_full_i) begin
                            r_timer  <= '0;
                            r_bstate <= B_WAIT;
                        end else begin
                            r_ack    <= 1'b1;
                            r_bstate <= B_ACK;
                            if (!wbs_we_i) r_dat <= w_io ? w_result : w_status;
                        end
                    end
                end
                B_WAIT: begin
                    if (!w_req) begin
                        r_bstate <= B_IDLE;
                    end else if (!fifo_full_i) begin
                        r_ack    <= 1'b1;
                        r_bstate <= B_ACK;
                    end else if (r_timer == c_TIMER_MAX) begin
                        r_ovf    <= 1'b1;
                        r_ack    <= 1'b1;
                        r_bstate <= B_ACK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                B_ACK: begin
                    r_dat    <= '0;
                    r_bstate <= B_IDLE;
                end
                default: r_bstate <= B_IDLE;
            endcase
        end
    end

    nn_run_sequencer #(
        .DEPTH_W (DEPTH_W)
    ) u_seq (
        .clk          (wb_clk_i),
        .rst_n        (wb_rst_ni),
        .i_start      (w_start),
        .i_clear      (w_clear),
        .i_len_we     (w_len_we),
        .i_len        (wbs_dat_i[c_CTRL_LEN_LSB +: DEPTH_W + 1]),
        .i_fifo_count (fifo_count_i),
        .i_nn_done    (nn_done_i),
        .i_nn_result  (nn_result_i),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_len        (w_len),
        .o_result     (w_result),
        .o_nn_start   (nn_start_o),
        .o_nn_len     (nn_len_o)
    );

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign fifo_push_o  = w_push;
    assign fifo_wdata_o = w_push ? wbs_dat_i : 32'h0;
    assign irq_o        = w_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_nn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wishbone_nn_ctrl                                                  |
// | Directed self-checking bench for wishbone_nn_ctrl.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wishbone_nn_ctrl;

    localparam logic [31:0] c_IO   = 32'h3000_0000;
    localparam logic [31:0] c_CTRL = 32'h3000_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        push;
    logic [31:0] wdata;
    logic        full;
    logic [4:0]  count;
    logic        nn_start;
    logic [4:0]  nn_len;
    logic        nn_done;
    logic [31:0] nn_result;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int start_pulses = 0;

    always #5 clk = ~clk;

    wishbone_nn_ctrl #(
        .IO_ADDRESS   (c_IO),
        .CTRL_ADDRESS (c_CTRL),
        .DEPTH_W      (4),
        .TIMEOUT      (16)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (dat_i),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .fifo_push_o  (push),
        .fifo_wdata_o (wdata),
        .fifo_full_i  (full),
        .fifo_count_i (count),
        .nn_start_o   (nn_start),
        .nn_len_o     (nn_len),
        .nn_done_i    (nn_done),
        .nn_result_i  (nn_result),
        .irq_o        (irq)
    );

    always @(negedge clk) if (nn_start) start_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; full is held high for the first full_cycles cycles.
    task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int full_cycles,
                             output int lat, output int npush, output int push_at,
                             output logic [31:0] pdata, output logic [31:0] rdata);
        lat = -1; npush = 0; push_at = -1; pdata = '0; rdata = '0;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int k = 0; k < 40; k++) begin
            full = (k < full_cycles);
            @(negedge clk);
            if (push) begin npush++; push_at = k; pdata = wdata; end
            if (ack) begin lat = k; rdata = dat_o; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; full = 1'b0; dat_i = '0; sel = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [31:0] r);
        nn_result = r; nn_done = 1'b1;
        @(posedge clk); #1;
        nn_done = 1'b0; nn_result = '0;
    endtask

    initial begin
        int lat, np, pat, s0, at, acks;
        logic [31:0] pd, rd;
        logic [4:0] seen_len;

        rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
        full = 0; count = 0; nn_done = 0; nn_result = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_push", 32'(push), 0);
        chk("rst_start", 32'(nn_start), 0);
        chk("rst_nnlen", 32'(nn_len), 0);
        chk("rst_irq", 32'(irq), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // Plain push, FIFO not full
        bus_cycle(1, c_IO, 32'hDEADBEEF, 4'hF, 0, lat, np, pat, pd, rd);
        chk("push_lat", 32'(lat), 1);
        chk("push_cnt", 32'(np), 1);
        chk("push_at", 32'(pat), 0);
        chk("push_data", pd, 32'hDEADBEEF);
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 0);
        @(posedge clk); #1;

        // Timeout on a full FIFO
        bus_cycle(1, c_IO, 32'hCAFE0001, 4'hF, 20, lat, np, pat, pd, rd);
        chk("to_lat", 32'(lat), 17);
        chk("to_push", 32'(np), 0);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("to_status", rd, 32'h0000_0004);
        chk("rd_lat", 32'(lat), 1);
        bus_cycle(1, c_CTRL, 32'h2, 4'hF, 0, lat, np, pat, pd, rd);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("ovf_clear", rd, 32'h0);

        // Full drops after 5 cycles
        bus_cycle(1, c_IO, 32'h1234_5678, 4'hF, 5, lat, np, pat, pd, rd);
        chk("bp_push_at", 32'(pat), 5);
        chk("bp_lat", 32'(lat), 6);
        chk("bp_cnt", 32'(np), 1);
        chk("bp_data", pd, 32'h1234_5678);

        // Partial select: acked, not pushed
        bus_cycle(1, c_IO, 32'hAAAA_5555, 4'h3, 0, lat, np, pat, pd, rd);
        chk("psel_lat", 32'(lat), 1);
        chk("psel_push", 32'(np), 0);

        // Address miss never acks
        stb = 1; cyc = 1; we = 0; adr = c_IO + 32'd8; acks = 0;
        repeat (5) begin @(negedge clk); if (ack) acks++; end
        @(posedge clk); #1 stb = 0; cyc = 0; adr = 0;
        chk("miss_ack", 32'(acks), 0);

        // Run with len=4, count ramps 0..4
        s0 = start_pulses; count = 0;
        bus_cycle(1, c_CTRL, 32'h0000_0405, 4'hF, 0, lat, np, pat, pd, rd);
        at = -1; seen_len = '0;
        for (int k = 0; k < 10; k++) begin
            count = (k < 4) ? 5'(k) : 5'd4;
            @(negedge clk);
            if (nn_start) begin at = k; seen_len = nn_len; end
            @(posedge clk); #1;
        end
        chk("run_start_at", 32'(at), 5);
        chk("run_nnlen", 32'(seen_len), 4);
        chk("run_pulses", 32'(start_pulses - s0), 1);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("run_status", rd, 32'h0004_0409);

        // Start while busy (also rewrites len)
        bus_cycle(1, c_CTRL, 32'h0000_0105, 4'hF, 0, lat, np, pat, pd, rd);
        idle(3);
        chk("busy_start_pulses", 32'(start_pulses - s0), 1);
        chk("busy_nnlen", 32'(nn_len), 4);

        // Completion
        pulse_done(32'h12);
        @(negedge clk);
        chk("done_irq", 32'(irq), 1);
        @(posedge clk); #1;
        bus_cycle(0, c_IO, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("result", rd, 32'h12);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("done_status", rd, 32'h0001_040A);

        // Done outside N_RUN ignored
        pulse_done(32'h99);
        bus_cycle(0, c_IO, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("stray_done", rd, 32'h12);

        // Start with len=0 ignored
        s0 = start_pulses;
        bus_cycle(1, c_CTRL, 32'h0000_0001, 4'hF, 0, lat, np, pat, pd, rd);
        idle(3);
        chk("len0_pulses", 32'(start_pulses - s0), 0);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("len0_status", rd, 32'h0000_0402);
        chk("len0_irq", 32'(irq), 0);

        // Reset during N_RUN and B_WAIT
        bus_cycle(1, c_CTRL, 32'h0000_0201, 4'hF, 0, lat, np, pat, pd, rd);
        idle(3);
        chk("run2_pulses", 32'(start_pulses - s0), 1);
        chk("run2_nnlen", 32'(nn_len), 2);
        stb = 1; cyc = 1; we = 1; adr = c_IO; dat_i = 32'h55; sel = 4'hF; full = 1;
        repeat (3) @(posedge clk);
        #3;
        full = 0; rst_n = 1'b0;
        #1;
        chk("arst_ack", 32'(ack), 0);
        chk("arst_push", 32'(push), 0);
        chk("arst_wdata", wdata, 0);
        chk("arst_start", 32'(nn_start), 0);
        chk("arst_nnlen", 32'(nn_len), 0);
        chk("arst_dat", dat_o, 0);
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0; dat_i = 0; sel = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        s0 = start_pulses;
        idle(1);
        pulse_done(32'h77);
        idle(2);
        bus_cycle(0, c_IO, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("post_rst_result", rd, 32'h0);
        bus_cycle(0, c_CTRL, 0, 4'hF, 0, lat, np, pat, pd, rd);
        chk("post_rst_status", rd, 32'h0000_0400);
        chk("post_rst_pulses", 32'(start_pulses - s0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
